// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W = 10;
    localparam int unsigned IMEM_DEPTH  = 256;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into 32-bit words; flags the byte that completes a word.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_ready
);

    // Only the first three bytes need storage; the fourth is taken straight from data.
    logic [23:0] shreg_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shreg_q <= {shreg_q[15:0], data};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    assign word       = {shreg_q, data};
    assign word_ready = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory, holding the CPU until the load completes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-2:0] len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W-2:0] MaxLen = (ADDR_W-1)'(DEPTH);
    localparam logic [ADDR_W-2:0] LenOne = 1;
    localparam logic [ADDR_W-3:0] IdxOne = 1;

    state_e            state_q;
    logic [ADDR_W-2:0] len_q;
    logic [ADDR_W-3:0] word_idx_q;

    logic        start_ok;
    logic        last_word;
    logic [31:0] packed_word;
    logic        word_ready;

    assign start_ok  = (state_q == StIdle) && start && (len != '0) && (len <= MaxLen);
    assign last_word = ({1'b0, word_idx_q} == (len_q - LenOne));

    byte_packer u_byte_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .shift_en   (s_valid && s_ready),
        .data       (s_data),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_idx_q <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            checksum   <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        len_q      <= len;
                        word_idx_q <= '0;
                        checksum   <= '0;
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= StCollect;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                StCollect: begin
                    if (word_ready) begin
                        s_ready    <= 1'b0;
                        imem_we    <= 1'b1;
                        imem_addr  <= {word_idx_q, 2'b00};
                        imem_wdata <= packed_word;
                        state_q    <= StWrite;
                    end
                end
                StWrite: begin
                    checksum <= checksum ^ imem_wdata;
                    if (last_word) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        word_idx_q <= word_idx_q + IdxOne;
                        s_ready    <= 1'b1;
                        state_q    <= StCollect;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_hold = busy;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are streamed.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int wr_cnt   = 0;
    logic [41:0] exp_q[$];
    logic [31:0] model_csum;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every write the DUT issues must match the head of the scoreboard.
    always @(negedge clk) begin
        if (imem_we) begin
            logic [41:0] exp;
            wr_cnt++;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         imem_addr, imem_wdata);
            end else begin
                exp = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== exp)
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_wdata, exp[41:32], exp[31:0]);
                else pass_cnt++;
            end
        end
        if (cpu_hold !== busy) begin
            chk_cnt++;
            $display("FAIL cpu_hold: got %b, required %b", cpu_hold, busy);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] n);
        start = 1'b1;
        len   = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 20) begin
            cyc();
            n++;
        end
        chk_cnt++;
        if (!s_ready) $display("FAIL send_byte: s_ready stuck low, required high");
        else pass_cnt++;
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] addr, input logic [31:0] w);
        exp_q.push_back({addr, w});
        model_csum ^= w;
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk_cnt++;
        if (done !== 1'b1) $display("FAIL wait_done: done never pulsed");
        else pass_cnt++;
        chk_cnt++;
        if (checksum !== model_csum)
            $display("FAIL checksum: got %h, required %h", checksum, model_csum);
        else pass_cnt++;
        cyc();
        chk_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_end: got done=%b busy=%b, required 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        chk_cnt++;
        if ({s_ready, imem_we, busy, cpu_hold, done, err} !== 6'b0 || imem_addr !== 10'h0 ||
            imem_wdata !== 32'h0 || checksum !== 32'h0)
            $display("FAIL reset: got ctl=%b addr=%h data=%h csum=%h, required all zero",
                     {s_ready, imem_we, busy, cpu_hold, done, err}, imem_addr, imem_wdata,
                     checksum);
        else pass_cnt++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_two_word();
        model_csum = 32'h0;
        do_start(9'd2);
        chk_cnt++;
        if (s_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL two_word_start: got s_ready=%b busy=%b, required 1 1", s_ready, busy);
        else pass_cnt++;
        send_word(10'h000, 32'h8C01_0000);
        send_word(10'h004, 32'h8C02_0004);
        wait_done();
        chk_cnt++;
        if (checksum !== 32'h0003_0004)
            $display("FAIL two_word_csum: got %h, required 00030004", checksum);
        else pass_cnt++;
    endtask

    task automatic test_invalid_len();
        logic [8:0] bad [2];
        bad[0] = 9'd0;
        bad[1] = 9'd257;
        for (int i = 0; i < 2; i++) begin
            do_start(bad[i]);
            chk_cnt++;
            if (err !== 1'b1 || busy !== 1'b0 || imem_we !== 1'b0 || checksum !== model_csum)
                $display("FAIL invalid_len: len=%0d got err=%b busy=%b we=%b csum=%h, required 1 0 0 %h",
                         bad[i], err, busy, imem_we, checksum, model_csum);
            else pass_cnt++;
            cyc();
            chk_cnt++;
            if (err !== 1'b0) $display("FAIL invalid_len_pulse: got err=%b, required 0", err);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_pressure();
        logic [6:0]  pat  = 7'b1001011;
        logic [31:0] w    = 32'h1234_5678;
        int          k    = 3;
        int          wr0  = wr_cnt;
        model_csum = w;
        exp_q.push_back({10'h000, w});
        do_start(9'd1);
        for (int i = 6; i >= 0; i--) begin
            s_valid = pat[i];
            s_data  = pat[i] ? w[8*k +: 8] : 8'hXX;
            if (pat[i]) k--;
            cyc();
        end
        s_valid = 1'b0;
        chk_cnt++;
        if (imem_we !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL back_pressure_write: got we=%b s_ready=%b, required 1 0", imem_we, s_ready);
        else pass_cnt++;
        wait_done();
        chk_cnt++;
        if (wr_cnt - wr0 !== 1)
            $display("FAIL back_pressure_count: got %0d writes, required 1", wr_cnt - wr0);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        logic [31:0] w0 = 32'hCAFE_F00D;
        model_csum = w0;
        exp_q.push_back({10'h000, w0});
        do_start(9'd2);
        send_byte(w0[31:24]);
        start = 1'b1;
        len   = 9'd1;
        cyc();
        start = 1'b0;
        chk_cnt++;
        if (err !== 1'b0 || busy !== 1'b1)
            $display("FAIL start_busy: got err=%b busy=%b, required 0 1", err, busy);
        else pass_cnt++;
        for (int i = 2; i >= 0; i--) send_byte(w0[8*i +: 8]);
        send_word(10'h004, 32'h0BAD_BEEF);
        wait_done();
    endtask

    task automatic test_reset_mid_word();
        do_start(9'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        cyc();
        chk_cnt++;
        if ({s_ready, imem_we, busy, done, err} !== 5'b0 || imem_addr !== 10'h0 ||
            imem_wdata !== 32'h0 || checksum !== 32'h0)
            $display("FAIL reset_mid: got ctl=%b addr=%h data=%h csum=%h, required all zero",
                     {s_ready, imem_we, busy, done, err}, imem_addr, imem_wdata, checksum);
        else pass_cnt++;
        rst_n = 1'b1;
        cyc();
        model_csum = 32'h0;
        do_start(9'd1);
        send_word(10'h000, 32'hDEAD_BEEF);
        wait_done();
    endtask

    task automatic test_full_image();
        logic [31:0] w;
        model_csum = 32'h0;
        do_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'(~i), 8'(i * 3), 8'h5A};
            send_word(10'(i * 4), w);
        end
        chk_cnt++;
        if (imem_we !== 1'b1 || imem_addr !== 10'h3FC)
            $display("FAIL full_last: got we=%b addr=%h, required 1 3fc", imem_we, imem_addr);
        else pass_cnt++;
        cyc();
        chk_cnt++;
        if (done !== 1'b1) $display("FAIL full_done: got done=%b, required 1", done);
        else pass_cnt++;
        wait_done();
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        len     = 9'd0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        model_csum = 32'h0;
        #2;
        test_reset();
        test_two_word();
        test_invalid_len();
        test_back_pressure();
        test_start_while_busy();
        test_reset_mid_word();
        test_full_image();
        cyc();
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
